// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lends one combinational ALU to two requesters.
// Each operation is latched, issued for one cycle, and its result is returned to the winner.
module alu_arbiter #(
  parameter int unsigned BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [3:0]           fs0,
  input  logic [3:0]           fs1,
  input  logic [2:0]           sh0,
  input  logic [2:0]           sh1,
  input  logic [BUS_WIDTH-1:0] a0,
  input  logic [BUS_WIDTH-1:0] a1,
  input  logic [BUS_WIDTH-1:0] b0,
  input  logic [BUS_WIDTH-1:0] b1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic [3:0]           alu_fs,
  output logic [2:0]           alu_sh,
  output logic [BUS_WIDTH-1:0] alu_a,
  output logic [BUS_WIDTH-1:0] alu_b,
  input  logic [BUS_WIDTH-1:0] alu_f,
  input  logic                 alu_n,
  input  logic                 alu_z,
  input  logic                 alu_c,
  input  logic                 alu_v,
  input  logic                 alu_d,
  output logic                 rsp_valid,
  output logic                 rsp_id,
  output logic [BUS_WIDTH-1:0] rsp_f,
  output logic [4:0]           rsp_flags,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t               state_q, state_d;
  logic                 last_gnt_q, last_gnt_d;
  logic                 id_q, id_d;
  logic [3:0]           fs_q, fs_d;
  logic [2:0]           sh_q, sh_d;
  logic [BUS_WIDTH-1:0] a_q, a_d;
  logic [BUS_WIDTH-1:0] b_q, b_d;
  logic                 rsp_id_q, rsp_id_d;
  logic [BUS_WIDTH-1:0] rsp_f_q, rsp_f_d;
  logic [4:0]           rsp_flags_q, rsp_flags_d;
  logic                 win;

  // On a tie the requester that did not win last time gets the ALU.
  assign win = (req0 && req1) ? ~last_gnt_q : req1;

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    id_d        = id_q;
    fs_d        = fs_q;
    sh_d        = sh_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_id_d    = rsp_id_q;
    rsp_f_d     = rsp_f_q;
    rsp_flags_d = rsp_flags_q;
    case (state_q)
      IDLE, DONE: begin
        if (req0 || req1) begin
          state_d    = ISSUE;
          last_gnt_d = win;
          id_d       = win;
          fs_d       = win ? fs1 : fs0;
          sh_d       = win ? sh1 : sh0;
          a_d        = win ? a1 : a0;
          b_d        = win ? b1 : b0;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d     = DONE;
        rsp_id_d    = id_q;
        rsp_f_d     = alu_f;
        rsp_flags_d = {alu_n, alu_z, alu_c, alu_v, alu_d};
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_gnt_q  <= 1'b1;
      id_q        <= 1'b0;
      fs_q        <= '0;
      sh_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_id_q    <= 1'b0;
      rsp_f_q     <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      id_q        <= id_d;
      fs_q        <= fs_d;
      sh_q        <= sh_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_id_q    <= rsp_id_d;
      rsp_f_q     <= rsp_f_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign gnt0      = (state_q == ISSUE) && !id_q;
  assign gnt1      = (state_q == ISSUE) && id_q;
  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = rsp_id_q;
  assign rsp_f     = rsp_f_q;
  assign rsp_flags = rsp_flags_q;
  assign alu_fs    = fs_q;
  assign alu_sh    = sh_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU closing the loop.
module tb_alu_arbiter;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [3:0]   fs0, fs1;
  logic [2:0]   sh0, sh1;
  logic [W-1:0] a0, a1, b0, b1;
  logic         gnt0, gnt1;
  logic [3:0]   alu_fs;
  logic [2:0]   alu_sh;
  logic [W-1:0] alu_a, alu_b, alu_f;
  logic         alu_n, alu_z, alu_c, alu_v, alu_d;
  logic         rsp_valid, rsp_id, busy;
  logic [W-1:0] rsp_f;
  logic [4:0]   rsp_flags;

  int vectors = 0;
  int miscompares = 0;
  logic prev_valid = 1'b0;
  logic [12:0] ref_res;

  always #5 clk = ~clk;

  // Returns {F[7:0], N, Z, C, V, D}.
  function automatic logic [12:0] alu_model(input logic [3:0] fs, input logic [2:0] sh,
                                            input logic [7:0] a, input logic [7:0] b);
    logic [8:0]  s;
    logic [15:0] wide;
    logic [7:0]  f;
    logic        c, v, d;
    c = 1'b0; v = 1'b0; d = 1'b0; f = a; s = '0; wide = '0;
    case (fs)
      4'b0000: begin
        s = {1'b0, a} + {1'b0, b};
        f = s[7:0]; c = s[8];
        v = (a[7] == b[7]) && (f[7] != a[7]);
      end
      4'b1110: begin
        s = {1'b0, a} + {1'b0, ~b} + 9'd1;
        f = s[7:0]; c = s[8];
        v = (a[7] != b[7]) && (f[7] != a[7]);
      end
      4'b1001: begin
        wide = {8'h00, a} << sh;
        f = wide[7:0]; d = |wide[15:8];
      end
      4'b1011: f = a | b;
      4'b1111: f = a & b;
      default: f = a;
    endcase
    return {f, f[7], (f == 8'h00), c, v, d};
  endfunction

  assign {alu_f, alu_n, alu_z, alu_c, alu_v, alu_d} = alu_model(alu_fs, alu_sh, alu_a, alu_b);

  alu_arbiter #(.BUS_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .fs0(fs0), .fs1(fs1), .sh0(sh0), .sh1(sh1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1),
    .alu_fs(alu_fs), .alu_sh(alu_sh), .alu_a(alu_a), .alu_b(alu_b),
    .alu_f(alu_f), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v), .alu_d(alu_d),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_f(rsp_f), .rsp_flags(rsp_flags), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Invariants sampled mid-cycle: grants exclusive, responses never back-to-back.
  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt_exclusive", {31'b0, gnt0 & gnt1}, 32'd0);
      chk("rsp_not_consecutive", {31'b0, rsp_valid & prev_valid}, 32'd0);
      prev_valid <= rsp_valid;
    end else begin
      prev_valid <= 1'b0;
    end
  end

  initial begin
    rst = 1'b1; req0 = 0; req1 = 0; fs0 = '0; fs1 = '0; sh0 = '0; sh1 = '0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    #1;
    chk("rst_gnt", {30'b0, gnt0, gnt1}, 32'd0);
    chk("rst_valid_busy", {30'b0, rsp_valid, busy}, 32'd0);
    chk("rst_rsp", {18'b0, rsp_id, rsp_f, rsp_flags}, 32'd0);
    chk("rst_alu", {9'b0, alu_fs, alu_sh, alu_a, alu_b}, 32'd0);

    // Single add from requester 0.
    rst = 1'b0;
    req0 = 1; fs0 = 4'b0000; a0 = 8'h7F; b0 = 8'h01;
    tick();
    chk("add_gnt", {30'b0, gnt0, gnt1}, 32'b10);
    chk("add_alu_a", {24'b0, alu_a}, 32'h7F);
    chk("add_issue_valid", {31'b0, rsp_valid}, 32'd0);
    req0 = 0;
    tick();
    chk("add_valid", {30'b0, rsp_valid, rsp_id}, 32'b10);
    chk("add_f", {24'b0, rsp_f}, 32'h80);
    chk("add_flags", {27'b0, rsp_flags}, 32'b10010);
    tick();
    chk("add_idle", {30'b0, busy, rsp_valid}, 32'd0);
    chk("add_held", {24'b0, rsp_f}, 32'h80);

    // Continuous double request from reset: grants 0,1,0,1.
    rst = 1'b1; #1; rst = 1'b0;
    req0 = 1; fs0 = 4'b1011; a0 = 8'hF0; b0 = 8'h0F;
    req1 = 1; fs1 = 4'b1111; a1 = 8'hF0; b1 = 8'h0F;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rr%0d_gnt", i), {30'b0, gnt0, gnt1}, (i % 2 == 0) ? 32'b10 : 32'b01);
      tick();
      chk($sformatf("rr%0d_done", i), {29'b0, rsp_valid, gnt0, gnt1}, 32'b100);
      chk($sformatf("rr%0d_id", i), {31'b0, rsp_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("rr%0d_rsp", i), {19'b0, rsp_f, rsp_flags},
          (i % 2 == 0) ? {19'b0, 8'hFF, 5'b10000} : {19'b0, 8'h00, 5'b01000});
      if (i == 3) begin
        req0 = 0; req1 = 0;
      end
    end
    tick();
    chk("rr_idle", {31'b0, busy}, 32'd0);

    // Shift from requester 1, then operand registers persist in IDLE.
    req1 = 1; fs1 = 4'b1001; sh1 = 3'd3; a1 = 8'h11; b1 = 8'h00;
    tick();
    chk("shl_gnt", {30'b0, gnt0, gnt1}, 32'b01);
    req1 = 0;
    tick();
    chk("shl_rsp", {30'b0, rsp_valid, rsp_id}, 32'b11);
    chk("shl_f", {24'b0, rsp_f}, 32'h88);
    tick();
    tick();
    chk("shl_idle_busy", {31'b0, busy}, 32'd0);
    chk("shl_idle_alu", {25'b0, alu_fs, alu_sh}, {25'b0, 4'b1001, 3'd3});

    // Back-to-back DONE -> ISSUE with a fresh requester.
    req0 = 1; fs0 = 4'b0000; a0 = 8'h01; b0 = 8'h02;
    tick();
    chk("b2b_gnt0", {30'b0, gnt0, gnt1}, 32'b10);
    req0 = 0;
    tick();
    chk("b2b_done", {31'b0, rsp_valid}, 32'd1);
    chk("b2b_f0", {24'b0, rsp_f}, 32'h03);
    req1 = 1; fs1 = 4'b1111; a1 = 8'hFF; b1 = 8'h3C;
    tick();
    chk("b2b_gnt1", {29'b0, busy, gnt0, gnt1}, 32'b101);
    req1 = 0;
    tick();
    chk("b2b_rsp1", {23'b0, rsp_id, rsp_f}, {23'b0, 1'b1, 8'h3C});
    tick();

    // Reset during ISSUE aborts; held req0 restarts the operation.
    req0 = 1; fs0 = 4'b0000; a0 = 8'h10; b0 = 8'h20;
    tick();
    chk("abort_gnt", {30'b0, gnt0, gnt1}, 32'b10);
    #2; rst = 1'b1; #1;
    chk("abort_outs", {27'b0, gnt0, gnt1, rsp_valid, busy, rsp_id}, 32'd0);
    chk("abort_rsp", {19'b0, rsp_f, rsp_flags}, 32'd0);
    chk("abort_alu", {9'b0, alu_fs, alu_sh, alu_a, alu_b}, 32'd0);
    rst = 1'b0;
    tick();
    chk("restart_gnt", {30'b0, gnt0, gnt1}, 32'b10);
    chk("restart_alu_a", {24'b0, alu_a}, 32'h10);
    req0 = 0;
    tick();
    chk("restart_rsp", {22'b0, rsp_valid, rsp_id, rsp_f}, {22'b0, 1'b1, 1'b0, 8'h30});
    tick();

    // Subtract; flags checked against the reference ALU.
    req0 = 1; fs0 = 4'b1110; a0 = 8'h05; b0 = 8'h07;
    tick();
    req0 = 0;
    ref_res = alu_model(4'b1110, 3'd0, 8'h05, 8'h07);
    tick();
    chk("sub_f", {24'b0, rsp_f}, 32'hFE);
    chk("sub_flags", {27'b0, rsp_flags}, {27'b0, ref_res[4:0]});
    tick();

    // kb_input select code passes through unchanged.
    req1 = 1; fs1 = 4'b0101; sh1 = 3'd0; a1 = 8'h5A; b1 = 8'hA5;
    tick();
    chk("pass_fs", {28'b0, alu_fs}, 32'b0101);
    req1 = 0;
    tick();
    chk("pass_f", {24'b0, rsp_f}, 32'h5A);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
